pc_fetch_unit: RTL

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pmipsl_pkg.sv | 18 +
 rtl/return_stack.sv | 53 +++++
 rtl/pc_fetch_unit.sv | 104 ++++++++++
 3 files changed

// File: rtl/pmipsl_pkg.sv
// Shared definitions for the fetch stage: PC control encodings, default sizes
// and the opcode field position within an instruction word.
package pmipsl_pkg;

    localparam int DEFAULT_ADDR_W    = 16;
    localparam int DEFAULT_RAS_DEPTH = 4;

    localparam int OPCODE_HI = 15;
    localparam int OPCODE_LO = 12;

    typedef enum logic [1:0] {
        PC_STALL    = 2'd0,
        PC_INC      = 2'd1,
        PC_CONDLOAD = 2'd2,
        PC_RSVD     = 2'd3
    } pc_ctrl_e;

endpackage

// File: rtl/return_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry
// so the most recent DEPTH return addresses are always kept.
module return_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 16,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  push_data,
    output logic [W-1:0]  top_data,
    output logic [CW-1:0] count,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] sp;
    logic [PW-1:0] sp_inc;
    logic [PW-1:0] sp_dec;
    logic          full;

    // sp is the next write slot; when full it also points at the oldest entry
    assign sp_inc   = (sp == PW'(DEPTH - 1)) ? '0 : sp + PW'(1);
    assign sp_dec   = (sp == '0) ? PW'(DEPTH - 1) : sp - PW'(1);
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign top_data = mem[sp_dec];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sp    <= '0;
            count <= '0;
        end else if (push) begin
            sp <= sp_inc;
            if (!full) begin
                count <= count + CW'(1);
            end
        end else if (pop && !empty) begin
            sp    <= sp_dec;
            count <= count - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[sp] <= push_data;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: program counter, next-PC selection among increment,
// return, jump and branch targets, the IF/ID register and the return stack.
module pc_fetch_unit #(
    parameter int ADDR_W    = pmipsl_pkg::DEFAULT_ADDR_W,
    parameter int RAS_DEPTH = pmipsl_pkg::DEFAULT_RAS_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        PCControl,
    input  logic              JumpTaken,
    input  logic              LinkPush,
    input  logic              RetTaken,
    input  logic [ADDR_W-1:0] JumpAddr,
    input  logic              BranchTaken,
    input  logic [ADDR_W-1:0] BranchAddr,
    input  logic [ADDR_W-1:0] Instr,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] IFID_Instr,
    output logic [ADDR_W-1:0] IFID_PCPlus2,
    output logic [2:0]        RASCount,
    output logic              RASErr
);
    import pmipsl_pkg::*;

    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [ADDR_W-1:0] pc_plus2;
    logic [ADDR_W-1:0] pc_next;
    logic              ifid_load;
    logic              ras_push;
    logic              ras_pop;
    logic              err_set;
    logic [ADDR_W-1:0] ras_top;
    logic [CW-1:0]     ras_count;
    logic              ras_empty;

    assign pc_plus2 = PC + ADDR_W'(2);
    assign RASCount = 3'(ras_count);

    // Return beats jump beats branch; link and return flags only act under CondLoad
    always_comb begin
        pc_next   = PC;
        ifid_load = 1'b0;
        ras_push  = 1'b0;
        ras_pop   = 1'b0;
        err_set   = 1'b0;
        case (PCControl)
            PC_INC: begin
                pc_next   = pc_plus2;
                ifid_load = 1'b1;
            end
            PC_CONDLOAD: begin
                if (RetTaken) begin
                    if (ras_empty) begin
                        err_set = 1'b1;
                    end else begin
                        pc_next = ras_top;
                        ras_pop = 1'b1;
                    end
                end else if (JumpTaken) begin
                    pc_next  = {JumpAddr[ADDR_W-1:1], 1'b0};
                    ras_push = LinkPush;
                end else if (BranchTaken) begin
                    pc_next = {BranchAddr[ADDR_W-1:1], 1'b0};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            PC           <= '0;
            IFID_Instr   <= '0;
            IFID_PCPlus2 <= '0;
            RASErr       <= 1'b0;
        end else begin
            PC <= pc_next;
            if (ifid_load) begin
                IFID_Instr   <= Instr;
                IFID_PCPlus2 <= pc_plus2;
            end
            if (err_set) begin
                RASErr <= 1'b1;
            end
        end
    end

    // A jal's PC register already holds its own PC+2, which is the return address
    return_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (ADDR_W)
    ) u_ras (
        .clock     (clock),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (PC),
        .top_data  (ras_top),
        .count     (ras_count),
        .empty     (ras_empty)
    );

endmodule
